// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 big-endian words, then streams W[0..ROUNDS-1]
// from a 16-word sliding window. Define SHA256_SCHED_ABORT_EN to add the abort input.
module sha256_msg_sched #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SHA256_SCHED_ABORT_EN
  input  logic        abort,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] w_word,
  output logic [5:0]  w_idx,
  output logic        w_last,
  output logic        busy
);

  // Handshake rule on both ports: a word transfers on a rising clk edge where
  // valid && ready; valid never depends on ready, and held data stays stable.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2
  } state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [5:0]  t;
  logic [31:0] win [16];
  logic [31:0] w_new;
  logic        kill;
  logic        in_fire;
  logic        out_fire;

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

`ifdef SHA256_SCHED_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (cnt == 4'd15)) state_nxt = EXPAND;
      end
      EXPAND: begin
        out_valid = 1'b1;
        if (out_ready && (t == LAST_T)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort wins over any handshake in the same cycle.
    if (kill) state_nxt = IDLE;
  end

  assign in_fire  = in_valid && in_ready && !kill;
  assign out_fire = out_valid && out_ready && !kill;
  assign busy     = (state != IDLE);

  assign w_new = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
      t   <= 6'd0;
      for (int k = 0; k < 16; k++) win[k] <= 32'd0;
    end else if (kill) begin
      cnt <= 4'd0;
      t   <= 6'd0;
    end else begin
      // cnt is 0 in IDLE, so the first word lands in win[0]; 15+1 wraps to 0.
      if (in_fire) begin
        win[cnt] <= in_word;
        cnt      <= cnt + 4'd1;
      end
      if (out_fire) begin
        for (int k = 0; k < 15; k++) win[k] <= win[k+1];
        win[15] <= w_new;
        t       <= (t == LAST_T) ? 6'd0 : t + 6'd1;
      end
    end
  end

  assign w_word = (state == EXPAND) ? win[0] : 32'd0;
  assign w_idx  = t;
  assign w_last = (state == EXPAND) && (t == LAST_T);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched against a full-array SHA-256 schedule model.
module tb_sha256_msg_sched;
  localparam int ROUNDS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_word = 32'd0;
  logic        out_ready = 1'b0;
`ifdef SHA256_SCHED_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        in_ready;
  logic        out_valid;
  logic [31:0] w_word;
  logic [5:0]  w_idx;
  logic        w_last;
  logic        busy;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] blk [16];
  logic [31:0] got [64];

  sha256_msg_sched #(.ROUNDS(ROUNDS)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef SHA256_SCHED_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_word(in_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .w_word(w_word),
    .w_idx(w_idx),
    .w_last(w_last),
    .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_model();
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++) w[i] = ss1(w[i-2]) + w[i-7] + ss0(w[i-15]) + w[i-16];
    for (int i = 0; i < ROUNDS; i++) exp_q.push_back(w[i]);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  // driver tasks; callers are positioned at a falling edge
  task automatic load_block(input int max_gap, input int n_words);
    int g;
    for (int i = 0; i < n_words; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 1)) : 0;
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        in_word  = $urandom;
        @(negedge clk);
      end
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== (i != 0)) begin
        n_fail++;
        $display("FAIL load_flags word=%0d in_ready=%b out_valid=%b busy=%b want 1/0/%b",
                 i, in_ready, out_valid, busy, (i != 0));
      end
      in_valid = 1'b1;
      in_word  = blk[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_word  = $urandom;
    if (n_words == 16) begin
      n_checks++;
      if (out_valid !== 1'b1 || w_idx !== 6'd0) begin
        n_fail++;
        $display("FAIL first_latency out_valid=%b w_idx=%0d want 1/0", out_valid, w_idx);
      end
    end
  endtask

  task automatic collect(input int ready_pct, input int stop_at, input bit junk);
    int          cycles;
    int          idx;
    bit          stalled;
    bit          done;
    logic [31:0] held;
    cycles  = 0;
    idx     = 0;
    stalled = 1'b0;
    done    = 1'b0;
    held    = 32'd0;
    while (!done && cycles < 2000) begin
      if (stop_at >= 0 && idx == stop_at) break;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty idx=%0d", idx);
        break;
      end
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL expand_flags idx=%0d out_valid=%b in_ready=%b busy=%b want 1/0/1",
                 idx, out_valid, in_ready, busy);
      end
      if (stalled) begin
        n_checks++;
        if (w_word !== held) begin
          n_fail++;
          $display("FAIL stall_hold idx=%0d got=%h want=%h", idx, w_word, held);
        end
      end
      n_checks++;
      if (w_word !== exp_q[0] || w_idx !== 6'(idx) || w_last !== (idx == ROUNDS - 1)) begin
        n_fail++;
        $display("FAIL sched_word idx=%0d got=%h/%0d/%b want=%h/%0d/%b",
                 idx, w_word, w_idx, w_last, exp_q[0], idx, (idx == ROUNDS - 1));
      end
      out_ready = ($urandom_range(99, 0) < ready_pct);
      in_valid  = junk && !(out_ready && (idx == ROUNDS - 1));
      in_word   = $urandom;
      stalled   = !out_ready;
      held      = exp_q[0];
      if (out_ready) begin
        got[idx] = w_word;
        void'(exp_q.pop_front());
        idx++;
        if (idx == ROUNDS) done = 1'b1;
      end
      @(negedge clk);
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (cycles >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL collect_timeout idx=%0d", idx);
    end
    if (done) begin
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || w_last !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_last out_valid=%b busy=%b in_ready=%b w_last=%b want 0/0/1/0",
                 out_valid, busy, in_ready, w_last);
      end
    end
  endtask

  task automatic check_known_abc();
    n_checks++;
    if (got[16] !== 32'h61626380 || got[17] !== 32'h000F0000) begin
      n_fail++;
      $display("FAIL abc_kat got W16=%h W17=%h want 61626380/000f0000", got[16], got[17]);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (got[i] !== blk[i]) begin
        n_fail++;
        $display("FAIL abc_echo i=%0d got=%h want=%h", i, got[i], blk[i]);
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    #12;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || w_word !== 32'd0 || w_idx !== 6'd0 ||
        w_last !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values got rdy=%b vld=%b w=%h idx=%0d last=%b busy=%b want 1/0/0/0/0/0",
               in_ready, out_valid, w_word, w_idx, w_last, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abc();
    set_abc();
    push_model();
    load_block(0, 16);
    collect(100, -1, 1'b0);
    check_known_abc();
  endtask

  task automatic test_backpressure();
    set_abc();
    push_model();
    load_block(0, 16);
    collect(50, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
    push_model();
    load_block(0, 16);
    collect(100, -1, 1'b0);
    set_abc();
    push_model();
    load_block(0, 16);
    collect(100, -1, 1'b0);
    check_known_abc();
  endtask

  task automatic test_reset_mid_expand();
    set_abc();
    push_model();
    load_block(0, 16);
    collect(100, 20, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || w_word !== 32'd0 ||
        w_idx !== 6'd0) begin
      n_fail++;
      $display("FAIL async_reset got vld=%b busy=%b rdy=%b w=%h idx=%0d want 0/0/1/0/0",
               out_valid, busy, in_ready, w_word, w_idx);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_abc();
    push_model();
    load_block(0, 16);
    collect(100, -1, 1'b0);
    check_known_abc();
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      push_model();
      load_block(5, 16);
      collect(70, -1, 1'b1);
    end
  endtask

`ifdef SHA256_SCHED_ABORT_EN
  task automatic test_abort();
    set_abc();
    load_block(0, 7);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_word  = $urandom;
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_load busy=%b rdy=%b vld=%b want 0/1/0", busy, in_ready, out_valid);
    end
    push_model();
    load_block(0, 16);
    collect(100, 30, 1'b0);
    abort     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || w_idx !== 6'd0) begin
      n_fail++;
      $display("FAIL abort_expand busy=%b vld=%b idx=%0d want 0/0/0", busy, out_valid, w_idx);
    end
    exp_q.delete();
    push_model();
    load_block(0, 16);
    collect(100, -1, 1'b0);
    check_known_abc();
  endtask
`endif

  initial begin
    test_reset();
    test_abc();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_expand();
    test_gaps();
`ifdef SHA256_SCHED_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
